// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: writeback source encoding, FSM states, bit-reverse helper.
package mem_stage_pkg;
    localparam int WB_SRC_W = 3;

    typedef enum logic [WB_SRC_W-1:0] {
        WB_MEM  = 3'd0,
        WB_ALU  = 3'd1,
        WB_PC   = 3'd2,
        WB_SET  = 3'd3,
        WB_IMM8 = 3'd4,
        WB_SLBI = 3'd5,
        WB_BTR  = 3'd6,
        WB_RSVD = 3'd7
    } wb_src_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RD,
        ST_HALTED
    } state_e;

    function automatic logic [15:0] bit_rev16(input logic [15:0] v);
        return {<<{v}};
    endfunction
endpackage

// File: rtl/mem_stage_pipe_if.sv
// Data-memory req/gnt/rsp bus between the MEM stage (master) and the memory (slave).
interface mem_stage_pipe_if #(
    parameter int DATA_W = 16
) ();
    logic              mem_req;
    logic              mem_req_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_req_wr, mem_addr, mem_wdata,
        input  mem_gnt, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_req_wr, mem_addr, mem_wdata,
        output mem_gnt, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_wb_mux.sv
// Combinational writeback source select; flags the reserved select code. Zero latency, no flow control.
module mem_wb_mux import mem_stage_pkg::*; #(
    parameter int DATA_W = 16
) (
    input  wb_src_e           src,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] next_pc,
    input  logic [DATA_W-1:0] set_val,
    input  logic [DATA_W-1:0] reg1_data,
    input  logic [7:0]        imm8,
    output logic [DATA_W-1:0] data,
    output logic              bad_src
);
    always_comb begin
        data    = '0;
        bad_src = 1'b0;
        case (src)
            WB_MEM:  data = rdata;
            WB_ALU:  data = alu_out;
            WB_PC:   data = next_pc;
            WB_SET:  data = set_val;
            WB_IMM8: begin
                data      = {DATA_W{imm8[7]}};
                data[7:0] = imm8;
            end
            // Upper bits stay zero for wide datapaths
            WB_SLBI: data[15:0] = {reg1_data[7:0], imm8};
            WB_BTR:  data[15:0] = bit_rev16(reg1_data[15:0]);
            default: bad_src = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage + MEM/WB register: 1-cycle result latency, in_ready low while a memory access is pending.
// Optional MEM_ALIGN_CHECK_EN: odd memory addresses complete with err instead of issuing a request.
module mem_stage_pipe import mem_stage_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     reg1_data,
    input  logic [DATA_W-1:0]     reg2_data,
    input  logic [DATA_W-1:0]     next_pc,
    input  logic [DATA_W-1:0]     set_val,
    input  logic [15:0]           instr,
    input  logic                  mem_en,
    input  logic                  mem_wr,
    input  logic                  reg_wrt,
    input  logic [WB_SRC_W-1:0]   reg_wrt_src,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic                  halt,
    mem_stage_pipe_if.master      mem,
    output logic                  wb_valid,
    output logic                  wb_reg_wrt,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  halt_out,
    output logic                  err
);
    state_e            state;
    logic              misalign;
    logic              bad_src;
    logic              req;
    logic              go_wait;
    logic [DATA_W-1:0] sel_data;
    logic [7:0]        unused_instr_hi;

    assign unused_instr_hi = instr[15:8];

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_en & alu_out[0];
`else
    assign misalign = 1'b0;
`endif

    mem_wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .src       (wb_src_e'(reg_wrt_src)),
        .rdata     (mem.mem_rdata),
        .alu_out   (alu_out),
        .next_pc   (next_pc),
        .set_val   (set_val),
        .reg1_data (reg1_data),
        .imm8      (instr[7:0]),
        .data      (sel_data),
        .bad_src   (bad_src)
    );

    // A read granted together with its response completes without visiting WAIT_RD
    always_comb begin
        in_ready = 1'b0;
        req      = 1'b0;
        go_wait  = 1'b0;
        case (state)
            ST_IDLE, ST_REQ: begin
                if (in_valid) begin
                    if (!mem_en || misalign) begin
                        in_ready = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (mem.mem_gnt) begin
                            if (mem_wr || mem.mem_rsp_valid) in_ready = 1'b1;
                            else                             go_wait  = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_RD: in_ready = mem.mem_rsp_valid;
            default: ;
        endcase
        if (rst) begin
            in_ready = 1'b0;
            req      = 1'b0;
            go_wait  = 1'b0;
        end
    end

    assign mem.mem_req    = req;
    assign mem.mem_req_wr = req & mem_wr;
    assign mem.mem_addr   = alu_out;
    assign mem.mem_wdata  = reg2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wb_valid     <= 1'b0;
            wb_reg_wrt   <= 1'b0;
            wb_write_reg <= '0;
            wb_data      <= '0;
            halt_out     <= 1'b0;
            err          <= 1'b0;
        end else begin
            wb_valid   <= in_ready;
            wb_reg_wrt <= 1'b0;
            if (in_ready) begin
                wb_reg_wrt   <= reg_wrt & ~bad_src & ~misalign;
                wb_write_reg <= write_reg;
                wb_data      <= sel_data;
                if (bad_src || misalign) err      <= 1'b1;
                if (halt)                halt_out <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_REQ: begin
                    if (in_ready)     state <= halt ? ST_HALTED : ST_IDLE;
                    else if (go_wait) state <= ST_WAIT_RD;
                    else if (req)     state <= ST_REQ;
                end
                ST_WAIT_RD: if (in_ready) state <= halt ? ST_HALTED : ST_IDLE;
                default: state <= ST_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: directed cases, then randomized ops with a latency-randomized memory.
module tb_mem_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_out = '0, reg1_data = '0, reg2_data = '0, next_pc = '0, set_val = '0, instr = '0;
    logic        mem_en = 1'b0, mem_wr = 1'b0, reg_wrt = 1'b0, halt = 1'b0;
    logic [2:0]  reg_wrt_src = '0;
    logic [2:0]  write_reg = '0;
    logic        wb_valid, wb_reg_wrt, halt_out, err;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_data;

    always #5 clk = ~clk;

    mem_stage_pipe_if #(.DATA_W(16)) mif ();

    mem_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .next_pc(next_pc), .set_val(set_val), .instr(instr),
        .mem_en(mem_en), .mem_wr(mem_wr), .reg_wrt(reg_wrt), .reg_wrt_src(reg_wrt_src),
        .write_reg(write_reg), .halt(halt), .mem(mif),
        .wb_valid(wb_valid), .wb_reg_wrt(wb_reg_wrt), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .halt_out(halt_out), .err(err)
    );

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [15:0] alu, r1, r2, pc, setv, ins;
        logic        men, mwr, rw, hlt;
        logic [2:0]  src, wreg;
    } op_t;
    typedef struct { logic rw; logic [2:0] wreg; logic [15:0] data; logic bad; logic err; } wb_exp_t;
    typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } acc_t;

    wb_exp_t     exp_wb[$];
    acc_t        exp_acc[$];
    logic [15:0] ref_mem[16];
    logic [15:0] mem_arr[16];
    int          errors = 0;
    int          checks = 0;
    bit          err_sticky = 1'b0;
    int          gnt_fix = -1;
    int          rsp_fix = -1;
    bit          spur_en = 1'b0;
    bit          mm_pend = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic logic [15:0] ref_val(input op_t o, input logic [15:0] rd);
        logic [15:0] r;
        r = '0;
        case (o.src)
            3'd0: r = rd;
            3'd1: r = o.alu;
            3'd2: r = o.pc;
            3'd3: r = o.setv;
            3'd4: r = {{8{o.ins[7]}}, o.ins[7:0]};
            3'd5: r = {o.r1[7:0], o.ins[7:0]};
            3'd6: for (int i = 0; i < 16; i++) r[i] = o.r1[15-i];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic op_t base_op();
        op_t o;
        o.alu = '0; o.r1 = '0; o.r2 = '0; o.pc = '0; o.setv = '0; o.ins = '0;
        o.men = 1'b0; o.mwr = 1'b0; o.rw = 1'b0; o.hlt = 1'b0; o.src = 3'd1; o.wreg = '0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  k;
        o = base_op();
        o.alu = 16'($urandom); o.r1 = 16'($urandom); o.r2 = 16'($urandom);
        o.pc = 16'($urandom); o.setv = 16'($urandom); o.ins = 16'($urandom);
        o.wreg = 3'($urandom);
        k = $urandom_range(0, 3);
        if (k == 1) begin
            o.men = 1'b1; o.src = 3'd0; o.rw = 1'($urandom);
        end else if (k == 2) begin
            o.men = 1'b1; o.mwr = 1'b1; o.src = 3'($urandom_range(1, 6));
        end else begin
            o.src = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(1, 6));
            o.rw  = 1'($urandom);
        end
        return o;
    endfunction

    task automatic drive(input op_t o);
        alu_out = o.alu; reg1_data = o.r1; reg2_data = o.r2; next_pc = o.pc;
        set_val = o.setv; instr = o.ins; mem_en = o.men; mem_wr = o.mwr;
        reg_wrt = o.rw; reg_wrt_src = o.src; write_reg = o.wreg; halt = o.hlt;
        in_valid = 1'b1;
    endtask

    // Reference: program-order memory image plus sticky error flag
    task automatic expect_op(input op_t o);
        bit          mis, bad;
        logic [15:0] rd;
        wb_exp_t     e;
        acc_t        a;
        mis = ALIGN && o.men && o.alu[0];
        bad = (o.src == 3'd7) || mis;
        rd  = '0;
        if (o.men && !mis) begin
            a.wr = o.mwr; a.addr = o.alu; a.wdata = o.r2;
            exp_acc.push_back(a);
            if (o.mwr) ref_mem[o.alu[4:1]] = o.r2;
            else       rd = ref_mem[o.alu[4:1]];
        end
        if (bad) err_sticky = 1'b1;
        e.rw = o.rw && !bad; e.wreg = o.wreg; e.data = ref_val(o, rd); e.bad = bad; e.err = err_sticky;
        exp_wb.push_back(e);
    endtask

    task automatic wait_done(output int cyc);
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else begin
                cyc++;
                if (cyc > 100) begin
                    fail_now("in_ready_timeout");
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input op_t o, output int cyc);
        drive(o);
        expect_op(o);
        wait_done(cyc);
    endtask

    // Memory model: variable grant/response delay, optional spurious responses
    initial begin
        bit   req_act;
        bit   got_rsp;
        int   gcnt, rcnt, d;
        logic [15:0] rbuf;
        acc_t a;
        req_act = 1'b0; gcnt = 0; rcnt = 0; rbuf = '0;
        mif.mem_gnt = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            mif.mem_gnt = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 16'($urandom);
            got_rsp = 1'b0;
            if (mm_pend) begin
                if (rcnt == 0) begin
                    mif.mem_rsp_valid = 1'b1; mif.mem_rdata = rbuf; mm_pend = 1'b0; got_rsp = 1'b1;
                end else rcnt--;
            end
            if (mif.mem_req) begin
                chk("single_outstanding", 32'(mm_pend), 32'd0);
                if (!req_act) begin
                    req_act = 1'b1;
                    gcnt = (gnt_fix >= 0) ? gnt_fix : $urandom_range(0, 3);
                end
                if (gcnt == 0) begin
                    mif.mem_gnt = 1'b1;
                    req_act = 1'b0;
                    if (exp_acc.size() == 0) fail_now("unexpected_mem_req");
                    else begin
                        a = exp_acc.pop_front();
                        chk("acc_wr", 32'(mif.mem_req_wr), 32'(a.wr));
                        chk("acc_addr", 32'(mif.mem_addr), 32'(a.addr));
                        if (a.wr) chk("acc_wdata", 32'(mif.mem_wdata), 32'(a.wdata));
                    end
                    if (mif.mem_req_wr) mem_arr[mif.mem_addr[4:1]] = mif.mem_wdata;
                    else begin
                        rbuf = mem_arr[mif.mem_addr[4:1]];
                        d = (rsp_fix >= 0) ? rsp_fix : $urandom_range(0, 3);
                        if (d == 0) begin
                            mif.mem_rsp_valid = 1'b1; mif.mem_rdata = rbuf;
                        end else begin
                            mm_pend = 1'b1; rcnt = d - 1;
                        end
                    end
                end else gcnt--;
            end else begin
                req_act = 1'b0;
                if (!mm_pend && !got_rsp && spur_en && $urandom_range(0, 3) == 0)
                    mif.mem_rsp_valid = 1'b1;
            end
        end
    end

    // Monitor: one pop per wb_valid pulse, hold checks on bubbles
    initial begin
        logic [15:0] last;
        bit          known;
        wb_exp_t     e;
        last = '0; known = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = '0; known = 1'b1;
            end else if (wb_valid) begin
                if (exp_wb.size() == 0) fail_now("unexpected_wb_valid");
                else begin
                    e = exp_wb.pop_front();
                    chk("wb_reg_wrt", 32'(wb_reg_wrt), 32'(e.rw));
                    chk("wb_write_reg", 32'(wb_write_reg), 32'(e.wreg));
                    if (!e.bad) chk("wb_data", 32'(wb_data), 32'(e.data));
                    chk("err", 32'(err), 32'(e.err));
                    last = e.data; known = !e.bad;
                end
            end else begin
                chk("bubble_reg_wrt", 32'(wb_reg_wrt), 32'd0);
                if (known) chk("bubble_hold", 32'(wb_data), 32'(last));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        int  cyc;
        int  n;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'(i * 16'h1111) ^ 16'h5A3C;
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[8] = 16'hBEEF; mem_arr[8] = 16'hBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_wrt", 32'(wb_reg_wrt), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_write_reg", 32'(wb_write_reg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_halt_out", 32'(halt_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        o = base_op(); o.src = 3'd1; o.alu = 16'h1234; o.rw = 1'b1; o.wreg = 3'd3;
        issue(o, cyc);
        chk("alu_latency", 32'(cyc), 32'd0);

        gnt_fix = 2; rsp_fix = 3;
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0010; o.rw = 1'b1; o.wreg = 3'd5;
        issue(o, cyc);
        chk("load_wait_cycles", 32'(cyc), 32'd5);

        gnt_fix = 0;
        o = base_op(); o.men = 1'b1; o.mwr = 1'b1; o.alu = 16'h0020; o.r2 = 16'h5A5A; o.rw = 1'b0;
        issue(o, cyc);
        chk("store_latency", 32'(cyc), 32'd0);

        o = base_op(); o.src = 3'd4; o.ins = 16'h0080; o.rw = 1'b1; o.wreg = 3'd1; issue(o, cyc);
        o = base_op(); o.src = 3'd6; o.r1 = 16'h0001; o.rw = 1'b1; o.wreg = 3'd2; issue(o, cyc);
        o = base_op(); o.src = 3'd5; o.r1 = 16'h12AB; o.ins = 16'h00CD; o.rw = 1'b1; issue(o, cyc);
        o = base_op(); o.src = 3'd3; o.setv = 16'h0001; o.rw = 1'b1; issue(o, cyc);
        o = base_op(); o.src = 3'd7; o.rw = 1'b1; o.wreg = 3'd6; issue(o, cyc);
        o = base_op(); o.src = 3'd2; o.pc = 16'h0102; o.rw = 1'b1; issue(o, cyc);

        // Reset while a request waits for grant, then while a read waits for data
        gnt_fix = 10;
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0004; o.rw = 1'b1;
        drive(o);
        repeat (2) begin
            @(negedge clk);
            chk("req_held", 32'(mif.mem_req), 32'd1);
            chk("req_not_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("req_drops_in_rst", 32'(mif.mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; err_sticky = 1'b0;
        gnt_fix = 0; rsp_fix = 4;
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0008; o.rw = 1'b1;
        drive(o);
        exp_acc.push_back('{1'b0, 16'h0008, 16'h0000});
        @(negedge clk);
        chk("wait_rd_not_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait_mem_req", 32'(mif.mem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (mm_pend && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("late_rsp_drained", 32'(mm_pend), 32'd0);
        repeat (2) @(posedge clk); #1;
        chk("rst_clears_err", 32'(err), 32'd0);

        gnt_fix = 1; rsp_fix = 1;
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0010; o.rw = 1'b1; o.wreg = 3'd7;
        issue(o, cyc);
        chk("load_after_rst_cycles", 32'(cyc), 32'd2);
        gnt_fix = 0; rsp_fix = 0;
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0006; o.rw = 1'b1;
        issue(o, cyc);
        chk("zero_wait_read", 32'(cyc), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0011; o.rw = 1'b1;
        issue(o, cyc);
        chk("misalign_latency", 32'(cyc), 32'd0);
`endif

        gnt_fix = -1; rsp_fix = -1; spur_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            o = rand_op();
            issue(o, cyc);
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk); #1;
            end
        end

        o = base_op(); o.src = 3'd1; o.alu = 16'h00AA; o.rw = 1'b1; o.hlt = 1'b1;
        issue(o, cyc);
        @(negedge clk);
        chk("halt_out", 32'(halt_out), 32'd1);
        o = base_op(); o.men = 1'b1; o.src = 3'd0; o.alu = 16'h0002; o.rw = 1'b1;
        drive(o);
        repeat (5) begin
            @(negedge clk);
            chk("halted_in_ready", 32'(in_ready), 32'd0);
            chk("halted_mem_req", 32'(mif.mem_req), 32'd0);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("halt_sticky", 32'(halt_out), 32'd1);
        chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        chk("acc_queue_drained", 32'(exp_acc.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
